kgd_fill: RTL and testbench
===========================

Name: kgd_fill

Overview:
- Wishbone-programmable fill engine for the KGD graphics controller's video memory.
- The CPU loads a start byte address, byte count and pattern, then sets GO. The engine issues its own Wishbone master cycles to the KGD address and data registers, one address write plus one data write per byte.
- Sits between a CPU-side slave decode and a master port that the bus fabric muxes onto the KGD slave.
- Used for screen clear and rectangle fill without CPU byte loops.

Parameters:
- AW, 14, video-memory byte address width; matches the KGD address register.
- ACK_TIMEOUT, 255, maximum wb_clk_i cycles to wait for m_ack_i per master cycle before aborting with ERR.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset
- wb_adr_i  in  3  slave register address; [2:1] selects the register
- wb_dat_i  in  16  slave write data
- wb_dat_o  out  16  slave read data, registered
- wb_cyc_i  in  1  slave cycle
- wb_stb_i  in  1  slave strobe
- wb_we_i  in  1  slave write enable
- wb_sel_i  in  2  slave byte selects
- wb_ack_o  out  1  slave acknowledge
- m_adr_o  out  3  master address to KGD (3'b100 = address reg, 3'b010 = data reg)
- m_dat_o  out  16  master write data
- m_cyc_o  out  1  master cycle
- m_stb_o  out  1  master strobe
- m_we_o  out  1  master write enable, always 1 when m_cyc_o is high
- m_sel_o  out  2  master byte selects
- m_ack_i  in  1  master acknowledge from KGD
- irq  out  1  interrupt request = DONE & IE

Behaviour:
- Reset: wb_rst_i, asynchronous, active-high; clock wb_clk_i.
  - Registers cleared to 0; FSM to IDLE.
  - wb_ack_o, wb_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, irq all 0.
  - Reset mid-operation drops m_cyc_o immediately; the partial fill is not resumed.
- Slave ack: wb_ack_o rises one cycle after cyc&stb and is held for one cycle; it does not re-assert while strobe stays high with ack already asserted.
- Register map (wb_adr_i[2:1]):
  - 00 CSR: bit0 GO (write-1 start; reads 0); bit1 ABORT (write-1; reads 0); bit6 IE; bit7 DONE (write-1 clears); bit14 ERR (write-1 clears); bit15 BUSY (read-only).
  - 01 ADR: current byte address [AW-1:0].
  - 10 CNT: bytes remaining [AW-1:0].
  - 11 PAT: pattern [7:0].
  - Byte-select rules apply to all writes; bits [7:0] need wb_sel_i[0], bits [15:8] need wb_sel_i[1].
- While BUSY:
  - Writes to ADR, CNT and PAT are ignored, and GO is ignored.
  - Reads of ADR and CNT return live values.
- GO with CNT=0: DONE is set the next cycle; no master cycles are issued.
- Starting a fill: GO with CNT≠0 clears DONE and ERR, sets BUSY and enters WADR.
- FSM states:
  - IDLE: m_cyc_o = 0. Moves to WADR on a valid GO.
  - WADR: m_cyc_o = m_stb_o = m_we_o = 1, m_adr_o = 3'b100, m_sel_o = 2'b11, m_dat_o = {2'b0, ADR}.
    - On m_ack_i: drop strobe for one cycle (GAP1), then go to WDAT.
  - WDAT: m_adr_o = 3'b010, m_sel_o = 2'b01, m_dat_o = {8'h00, PAT}.
    - On m_ack_i: ADR <= ADR+1, wrapping 2^AW-1 -> 0; CNT <= CNT-1.
    - Then GAP2 for one cycle. From GAP2, go to WADR if CNT≠0, else FIN.
  - FIN: BUSY <= 0, DONE <= 1, return to IDLE.
- m_cyc_o/m_stb_o are deasserted in the GAP states so that each KGD transfer is a separate cycle; the KGD slave's ack logic requires strobe to drop between transfers.
- ABORT:
  - Latched while BUSY; applied at the next GAP state.
  - The current transfer completes first; then the FSM goes to IDLE with BUSY = 0, DONE = 1, and ADR/CNT holding the remaining values.
  - ABORT in IDLE has no effect.
- Timeout: a per-transfer counter is cleared at the start of each WADR/WDAT. If it reaches ACK_TIMEOUT without m_ack_i:
  - m_cyc_o drops and the FSM goes to IDLE.
  - BUSY = 0, ERR = 1, DONE = 1.
- Simultaneous events:
  - A CSR write of DONE=1 in the same cycle that FIN sets DONE: set wins.
  - A GO write in the FIN cycle is ignored.
- irq is registered: it follows DONE & IE one cycle later.

Optional Feature:
- Macro: KGD_FILL_INC_EN.
- When defined: PAT bit8 = INC. If INC=1, PAT[7:0] increments (mod 256) on each WDAT ack, which gives test ramps.
- When undefined: PAT bit8 reads 0, writes to it are ignored, and the pattern stays constant.

Test Plan:
- ADR=0, CNT=3, PAT=8'hA5, GO -> master writes: (100, 0000), (010, 00A5), (100, 0001), (010, 00A5), (100, 0002), (010, 00A5). Then DONE=1, BUSY=0, ADR=3, CNT=0.
- ADR=14'h3FFF, CNT=2, GO -> address writes 3FFF then 0000 (wrap). Final ADR=1.
- CNT=0, GO -> no m_cyc_o; DONE=1 one cycle after the write; with IE=1, irq=1 one cycle later. Writing CSR bit7=1 -> DONE=0, irq=0.
- CNT=100, GO, then ABORT after 5 data acks -> the in-flight transfer finishes. Result: BUSY=0, DONE=1, CNT=94 or 95 depending on the abort point, ADR consistent with CNT.
- Hold m_ack_i=0 for ACK_TIMEOUT cycles during WADR -> m_cyc_o falls, ERR=1, DONE=1, BUSY=0. Writing 1 to CSR bit14 clears ERR.
- With KGD_FILL_INC_EN: PAT=9'h1FE, CNT=3 -> data bytes FE, FF, 00.

Source files
------------

// File: rtl/kgd_fill.sv
// kgd_fill: Wishbone fill engine writing a byte pattern into KGD video memory.
// Optional build macro KGD_FILL_INC_EN enables PAT bit8 (INC) for ramp fills.
module kgd_fill #(
  parameter int AW          = 14,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [2:0]  m_adr_o,
  output logic [15:0] m_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  input  logic        m_ack_i,
  output logic        irq
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WADR, S_GAP1, S_WDAT, S_GAP2, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [7:0]      pat_q, pat_d;
  logic            inc_q, inc_d;
  logic            ie_q, ie_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            abort_q, abort_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ack_q, ack_d;
  logic [15:0]     rdat_q, rdat_d;
  logic            irq_q, irq_d;

  logic            acc, wr, go, tmo_hit;
  logic [15:0]     pat_rd;
  logic            unused_ok;

  assign unused_ok = ^{1'b0, wb_adr_i[0], wb_dat_i[15]};

  assign acc     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr      = acc & wb_we_i;
  assign go      = wr & (wb_adr_i[2:1] == 2'b00) & wb_sel_i[0] & wb_dat_i[0];
  assign tmo_hit = (tmo_q == TW'(ACK_TIMEOUT - 1));
  assign pat_rd  = {7'b0, inc_q, pat_q};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign irq      = irq_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    inc_d   = inc_q;
    ie_d    = ie_q;
    done_d  = done_q;
    err_d   = err_q;
    busy_d  = busy_q;
    abort_d = abort_q;
    tmo_d   = '0;
    ack_d   = acc;
    rdat_d  = rdat_q;
    irq_d   = done_q & ie_q;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = 3'b000;
    m_sel_o = 2'b00;
    m_dat_o = 16'h0000;

    if (acc && !wb_we_i) begin
      case (wb_adr_i[2:1])
        2'b00:   rdat_d = {busy_q, err_q, 6'b0, done_q, ie_q, 6'b0};
        2'b01:   rdat_d = 16'(adr_q);
        2'b10:   rdat_d = 16'(cnt_q);
        default: rdat_d = pat_rd;
      endcase
    end

    // CPU writes first so FSM-driven DONE/ERR sets below take priority.
    if (wr) begin
      case (wb_adr_i[2:1])
        2'b00: begin
          if (wb_sel_i[0]) begin
            ie_d = wb_dat_i[6];
            if (wb_dat_i[7]) done_d = 1'b0;
            if (wb_dat_i[1] && busy_q) abort_d = 1'b1;
          end
          if (wb_sel_i[1] && wb_dat_i[14]) err_d = 1'b0;
        end
        2'b01: if (!busy_q) begin
          if (wb_sel_i[0]) adr_d[7:0]    = wb_dat_i[7:0];
          if (wb_sel_i[1]) adr_d[AW-1:8] = wb_dat_i[AW-1:8];
        end
        2'b10: if (!busy_q) begin
          if (wb_sel_i[0]) cnt_d[7:0]    = wb_dat_i[7:0];
          if (wb_sel_i[1]) cnt_d[AW-1:8] = wb_dat_i[AW-1:8];
        end
        default: if (!busy_q) begin
          if (wb_sel_i[0]) pat_d = wb_dat_i[7:0];
`ifdef KGD_FILL_INC_EN
          if (wb_sel_i[1]) inc_d = wb_dat_i[8];
`endif
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_WADR;
          end
        end
      end
      S_WADR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = 3'b100;
        m_sel_o = 2'b11;
        m_dat_o = 16'(adr_q);
        if (m_ack_i) begin
          state_d = S_GAP1;
        end else if (tmo_hit) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP1: begin
        if (abort_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WDAT;
        end
      end
      S_WDAT: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = 3'b010;
        m_sel_o = 2'b01;
        m_dat_o = {8'h00, pat_q};
        if (m_ack_i) begin
          adr_d = adr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (inc_q) pat_d = pat_q + 8'd1;
          state_d = S_GAP2;
        end else if (tmo_hit) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP2: begin
        if (abort_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          state_d = S_WADR;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      inc_q   <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      inc_q   <= inc_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_kgd_fill.sv
// tb_kgd_fill: directed bench for kgd_fill with a transfer-list model and a KGD slave stub.
module tb_kgd_fill;
  localparam int AW  = 14;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  wb_adr = '0;
  logic [15:0] wb_dat_w = '0;
  logic [15:0] wb_dat_r;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0]  wb_sel = '0;
  logic        wb_ack;
  logic [2:0]  m_adr;
  logic [15:0] m_dat;
  logic        m_cyc, m_stb, m_we;
  logic [1:0]  m_sel;
  logic        m_ack;
  logic        irq;
  logic        ack_en = 1'b1;

  always #5 clk = ~clk;

  kgd_fill #(.AW(AW), .ACK_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_ack_o(wb_ack),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_cyc_o(m_cyc), .m_stb_o(m_stb),
    .m_we_o(m_we), .m_sel_o(m_sel), .m_ack_i(m_ack), .irq(irq)
  );

  // KGD slave stub: registered single-cycle ack per strobe.
  always @(posedge clk or posedge rst)
    if (rst) m_ack <= 1'b0;
    else     m_ack <= m_cyc & m_stb & ~m_ack & ack_en;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
    logic [1:0]  s;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  int    data_acks = 0;
  logic  prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Expected transfer list for a fill: address then data per byte.
  task automatic fill_model(input logic [AW-1:0] adr, input int cnt, input logic [7:0] pat, input bit inc);
    logic [AW-1:0] a;
    logic [7:0]    p;
    a = adr;
    p = pat;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back('{a: 3'b100, d: 16'(a), s: 2'b11});
      exp_q.push_back('{a: 3'b010, d: {8'h00, p}, s: 2'b01});
      a = a + 1'b1;
      if (inc) p = p + 8'd1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_ack) check("stb_gap", {31'b0, m_stb}, 32'd0);
      if (m_cyc) check("we_hi", {31'b0, m_we}, 32'd1);
      if (m_cyc && m_stb && m_ack) begin
        xfer_t x;
        x = '{a: m_adr, d: m_dat, s: m_sel};
        obs_q.push_back(x);
        if (m_adr == 3'b010) data_acks++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(x), 32'hFFFF_FFFF);
        end else begin
          check("xfer", 32'(x), 32'(exp_q.pop_front()));
        end
      end
      prev_ack = m_cyc & m_stb & m_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic wb_xfer(input logic [1:0] r, input logic we, input logic [15:0] d,
                         input logic [1:0] s, output logic [15:0] rd);
    bit got;
    got = 0;
    @(negedge clk);
    wb_adr = {r, 1'b0}; wb_we = we; wb_dat_w = d; wb_sel = s;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_ack) begin got = 1; break; end
    end
    rd = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) check("slave_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] dummy;
    wb_xfer(r, 1'b1, d, s, dummy);
  endtask

  task automatic wb_read(input logic [1:0] r, output logic [15:0] d);
    wb_xfer(r, 1'b0, 16'h0, 2'b11, d);
  endtask

  task automatic wait_idle();
    logic [15:0] v;
    bit idle;
    idle = 0;
    for (int i = 0; i < 2000; i++) begin
      wb_read(2'b00, v);
      if (!v[15]) begin idle = 1; break; end
    end
    if (!idle) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_data_acks(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (data_acks >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("data_ack_wait", 32'(data_acks), 32'(n));
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] lit_d [6];
    logic [2:0]  lit_a [6];
    int n, c;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {8'b0, m_cyc, m_stb, m_we, m_sel, m_adr, wb_ack, irq},  32'd0);
    check("rst_dat", {m_dat, wb_dat_r}, 32'd0);
    rst = 1'b0;
    wb_read(2'b00, v); check("rst_csr", 32'(v), 32'h0);
    wb_read(2'b01, v); check("rst_adr", 32'(v), 32'h0);
    wb_read(2'b10, v); check("rst_cnt", 32'(v), 32'h0);
    wb_read(2'b11, v); check("rst_pat", 32'(v), 32'h0);

    // Basic fill of three bytes.
    wb_write(2'b01, 16'h0000, 2'b11);
    wb_write(2'b10, 16'd3, 2'b11);
    wb_write(2'b11, 16'h00A5, 2'b11);
    fill_model(14'h0000, 3, 8'hA5, 0);
    obs_q.delete();
    wb_write(2'b00, 16'h0001, 2'b01);
    wait_idle();
    check("t1_exp_empty", 32'(exp_q.size()), 32'd0);
    lit_a = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
    lit_d = '{16'h0000, 16'h00A5, 16'h0001, 16'h00A5, 16'h0002, 16'h00A5};
    check("t1_nxfer", 32'(obs_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("t1_lit", {13'b0, obs_q[i].a, obs_q[i].d}, {13'b0, lit_a[i], lit_d[i]});
    wb_read(2'b00, v); check("t1_csr", 32'(v), 32'h0080);
    wb_read(2'b01, v); check("t1_adr", 32'(v), 32'd3);
    wb_read(2'b10, v); check("t1_cnt", 32'(v), 32'd0);

    // Address wrap.
    wb_write(2'b01, 16'h3FFF, 2'b11);
    wb_write(2'b10, 16'd2, 2'b11);
    fill_model(14'h3FFF, 2, 8'hA5, 0);
    obs_q.delete();
    wb_write(2'b00, 16'h0001, 2'b01);
    wait_idle();
    check("wrap_a0", 32'(obs_q[0].d), 32'h3FFF);
    check("wrap_a1", 32'(obs_q[2].d), 32'h0000);
    wb_read(2'b01, v); check("wrap_adr", 32'(v), 32'd1);

    // Byte selects.
    wb_write(2'b01, 16'h3F55, 2'b01);
    wb_read(2'b01, v); check("sel_lo", 32'(v), 32'h0055);
    wb_write(2'b01, 16'h3F55, 2'b10);
    wb_read(2'b01, v); check("sel_hi", 32'(v), 32'h3F55);
    wb_write(2'b11, 16'h01FE, 2'b11);
    wb_read(2'b11, v);
`ifdef KGD_FILL_INC_EN
    check("pat_bit8", 32'(v), 32'h01FE);
`else
    check("pat_bit8", 32'(v), 32'h00FE);
`endif
    wb_write(2'b11, 16'h00A5, 2'b11);

    // CNT=0 GO, DONE and irq timing.
    wb_write(2'b10, 16'd0, 2'b11);
    wb_write(2'b00, 16'h0080, 2'b01);
    obs_q.delete();
    wb_write(2'b00, 16'h0041, 2'b01);
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    wb_read(2'b00, v); check("cnt0_csr", 32'(v), 32'h00C0);
    check("cnt0_noxfer", 32'(obs_q.size()), 32'd0);
    wb_write(2'b00, 16'h00C0, 2'b01);
    @(negedge clk);
    check("irq_clr", {31'b0, irq}, 32'd0);
    wb_read(2'b00, v); check("done_clr", 32'(v), 32'h0040);
    wb_write(2'b00, 16'h0000, 2'b01);

    // Abort mid-fill; ADR/PAT writes while busy must be ignored.
    wb_write(2'b01, 16'h0100, 2'b11);
    wb_write(2'b10, 16'd100, 2'b11);
    wb_write(2'b11, 16'h003C, 2'b11);
    fill_model(14'h0100, 100, 8'h3C, 0);
    data_acks = 0;
    wb_write(2'b00, 16'h0001, 2'b01);
    wb_write(2'b11, 16'h0011, 2'b11);
    wb_write(2'b01, 16'h0000, 2'b11);
    wait_data_acks(5);
    wb_write(2'b00, 16'h0002, 2'b01);
    wait_idle();
    wb_read(2'b10, v);
    c = int'(v);
    check("abort_cnt", {31'b0, (c == 94 || c == 95)}, 32'd1);
    check("abort_dacks", 32'(data_acks), 32'(100 - c));
    wb_read(2'b01, v); check("abort_adr", 32'(v), 32'(16'h0100 + 16'(100 - c)));
    wb_read(2'b00, v); check("abort_csr", 32'(v), 32'h0080);
    wb_read(2'b11, v); check("abort_pat", 32'(v), 32'h003C);
    exp_q.delete();

    // Ack timeout during WADR.
    ack_en = 1'b0;
    wb_write(2'b01, 16'h0010, 2'b11);
    wb_write(2'b10, 16'd2, 2'b11);
    wb_write(2'b00, 16'h0001, 2'b01);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_cyc) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    check("tmo_len", {31'b0, (n >= TMO && n <= TMO + 1)}, 32'd1);
    wb_read(2'b00, v); check("tmo_csr", 32'(v), 32'h4080);
    wb_read(2'b10, v); check("tmo_cnt", 32'(v), 32'd2);
    wb_write(2'b00, 16'h4080, 2'b10);
    wb_read(2'b00, v); check("err_clr", 32'(v), 32'h0080);
    ack_en = 1'b1;
    exp_q.delete();

    // Reset in the middle of a fill.
    wb_write(2'b01, 16'h0000, 2'b11);
    wb_write(2'b10, 16'd50, 2'b11);
    fill_model(14'h0000, 50, 8'h3C, 0);
    data_acks = 0;
    wb_write(2'b00, 16'h0001, 2'b01);
    wait_data_acks(2);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid_cyc", {31'b0, m_cyc}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("rst_mid_idle", {31'b0, m_cyc}, 32'd0);
    wb_read(2'b00, v); check("rst_mid_csr", 32'(v), 32'h0);
    wb_read(2'b10, v); check("rst_mid_cnt", 32'(v), 32'h0);

`ifdef KGD_FILL_INC_EN
    wb_write(2'b11, 16'h01FE, 2'b11);
    wb_write(2'b10, 16'd3, 2'b11);
    fill_model(14'h0000, 3, 8'hFE, 1);
    obs_q.delete();
    wb_write(2'b00, 16'h0001, 2'b01);
    wait_idle();
    check("inc_d0", 32'(obs_q[1].d), 32'h00FE);
    check("inc_d1", 32'(obs_q[3].d), 32'h00FF);
    check("inc_d2", 32'(obs_q[5].d), 32'h0000);
`endif

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
